// File: rtl/change_dispenser.sv
// change_dispenser: greedy three-tube coin payout with exact-change fault detection
module change_dispenser #(
  parameter int D_HI  = 10,
  parameter int D_MID = 5,
  parameter int D_LO  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      change,
  input  logic             change_valid,
  output logic             ready,
  input  logic             empty_hi,
  input  logic             empty_mid,
  input  logic             empty_lo,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic [31:0]      remaining,
  output logic [CNT_W-1:0] coin_count,
  output logic             done,
  output logic             fault,
  input  logic             fault_clr
);
  localparam logic [31:0] V_HI  = 32'(D_HI);
  localparam logic [31:0] V_MID = 32'(D_MID);
  localparam logic [31:0] V_LO  = 32'(D_LO);
  typedef enum logic [1:0] {IDLE, SEL, DISP, FLT} state_t;
  state_t state, state_d;
  logic [1:0] pick, coin_type_d;
  logic [31:0] coin_val, remaining_d;
  logic [CNT_W-1:0] coin_count_d;
  logic ready_d, coin_valid_d, done_d, fault_d, accept, paid;
  assign accept = state == IDLE && change_valid;
  assign paid = state == DISP && coin_ack;
  // largest eligible denomination first; 00 means nothing can be paid
  assign pick = (!empty_hi  && remaining >= V_HI)  ? 2'b01 :
                (!empty_mid && remaining >= V_MID) ? 2'b10 :
                (!empty_lo  && remaining >= V_LO)  ? 2'b11 : 2'b00;
  assign coin_val = coin_type == 2'b01 ? V_HI : coin_type == 2'b10 ? V_MID : V_LO;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      coin_valid <= 1'b0;
      coin_type  <= 2'b00;
      remaining  <= '0;
      coin_count <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      ready      <= ready_d;
      coin_valid <= coin_valid_d;
      coin_type  <= coin_type_d;
      remaining  <= remaining_d;
      coin_count <= coin_count_d;
      done       <= done_d;
      fault      <= fault_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = change_valid ? SEL : IDLE;
      SEL:  state_d = remaining == '0 ? IDLE : pick != 2'b00 ? DISP : FLT;
      DISP: state_d = coin_ack ? SEL : DISP;
      FLT:  state_d = fault_clr ? IDLE : FLT;
    endcase
  end
  always_comb begin
    ready_d      = state_d == IDLE;
    coin_valid_d = state_d == DISP;
    coin_type_d  = state == SEL ? pick : state_d == DISP ? coin_type : 2'b00;
    remaining_d  = accept ? change : paid ? remaining - coin_val :
                   (state == FLT && fault_clr) ? '0 : remaining;
    coin_count_d = accept ? '0 :
                   paid ? (&coin_count ? coin_count : coin_count + 1'b1) : coin_count;
    done_d       = state == SEL && remaining == '0;
    fault_d      = state_d == FLT;
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser (coin sequence, done, fault, reset)
module tb_change_dispenser;
  logic clk = 0, reset = 0;
  logic [31:0] change = 0;
  logic change_valid = 0, empty_hi = 0, empty_mid = 0, empty_lo = 0, coin_ack = 0, fault_clr = 0;
  logic ready, coin_valid, done, fault;
  logic [1:0] coin_type;
  logic [31:0] remaining;
  logic [7:0] coin_count;
  int total = 0, bad = 0, ack_dly = 0, n_done = 0, exp_done_n = 0;
  logic [1:0] exp_q[$];
  int done_q[$];
  localparam logic [1:0] HI = 2'b01, MID = 2'b10, LO = 2'b11;

  change_dispenser dut (
    .clk(clk), .reset(reset), .change(change), .change_valid(change_valid), .ready(ready),
    .empty_hi(empty_hi), .empty_mid(empty_mid), .empty_lo(empty_lo), .coin_valid(coin_valid),
    .coin_type(coin_type), .coin_ack(coin_ack), .remaining(remaining), .coin_count(coin_count),
    .done(done), .fault(fault), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // hopper model: acks each coin after ack_dly extra cycles
  initial begin
    int w = 0;
    forever begin
      @(posedge clk);
      #1 coin_ack = 0;
      if (coin_valid) begin
        if (w >= ack_dly) begin coin_ack = 1; w = 0; end
        else w++;
      end else w = 0;
    end
  end

  // monitor: new coins and done pulses are compared against the scoreboard queues
  initial begin
    logic pv = 0, pd = 0;
    logic [1:0] pt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin pv = 0; pd = 0; end
      else begin
        if (coin_valid && !pv) begin
          if (exp_q.size() == 0) chk("extra_coin", 1, 0);
          else chk("coin_type", 32'(coin_type), 32'(exp_q.pop_front()));
        end
        if (coin_valid && pv) chk("type_stable", 32'(coin_type), 32'(pt));
        if (done) begin
          n_done++;
          if (pd) chk("done_pulse", 32'(done), 0);
          if (done_q.size() == 0) chk("extra_done", 1, 0);
          else chk("done_count", 32'(coin_count), 32'(done_q.pop_front()));
          chk("done_rem", remaining, 0);
        end
        pv = coin_valid; pt = coin_type; pd = done;
      end
    end
  end

  task automatic req(input logic [31:0] c);
    @(posedge clk);
    #1 change = c; change_valid = 1;
    @(posedge clk);
    #1 change_valid = 0;
  endtask

  task automatic expect_done(input int cnt);
    done_q.push_back(cnt);
    exp_done_n++;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (n_done < exp_done_n && k < 300) begin @(posedge clk); k++; end
    chk(tag, 32'(n_done >= exp_done_n), 1);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_valid", 32'(coin_valid), 0);
    chk("rst_type", 32'(coin_type), 0);
    chk("rst_rem", remaining, 0);
    chk("rst_cnt", 32'(coin_count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    @(negedge clk) reset = 1;
    // T1
    exp_q = '{HI, HI, MID, LO, LO};
    expect_done(5);
    req(27);
    wait_done("t1_timeout");
    @(negedge clk) chk("t1_ready", 32'(ready), 1);
    // T2: done two edges after accept, no coin
    expect_done(0);
    req(0);
    @(negedge clk);
    chk("t2_ready_busy", 32'(ready), 0);
    chk("t2_done_early", 32'(done), 0);
    @(negedge clk);
    chk("t2_done", 32'(done), 1);
    chk("t2_ready", 32'(ready), 1);
    @(negedge clk) chk("t2_done_drop", 32'(done), 0);
    wait_done("t2_timeout");
    // T3
    empty_hi = 1;
    exp_q = '{MID, MID, MID};
    expect_done(3);
    req(15);
    wait_done("t3_timeout");
    empty_hi = 0;
    // T4: one MID then no way to pay 2
    empty_lo = 1;
    exp_q = '{MID};
    req(7);
    k = 0;
    while (!fault && k < 100) begin @(negedge clk); k++; end
    chk("t4_fault", 32'(fault), 1);
    @(negedge clk);
    chk("t4_rem", remaining, 2);
    chk("t4_cnt", 32'(coin_count), 1);
    chk("t4_ready", 32'(ready), 0);
    chk("t4_valid", 32'(coin_valid), 0);
    @(posedge clk);
    #1 fault_clr = 1; change_valid = 1; change = 9;
    @(posedge clk);
    #1 fault_clr = 0; change_valid = 0;
    @(negedge clk);
    chk("t4_clr_fault", 32'(fault), 0);
    chk("t4_clr_ready", 32'(ready), 1);
    chk("t4_clr_rem", remaining, 0);
    @(negedge clk) chk("t4_req_dropped", 32'(ready), 1);
    empty_lo = 0;
    // T5: slow hopper, stray requests mid-payout
    ack_dly = 5;
    exp_q = '{HI, HI};
    expect_done(2);
    req(20);
    repeat (3) begin
      repeat (3) @(posedge clk);
      #1 change = 5; change_valid = 1;
      @(posedge clk);
      #1 change_valid = 0;
    end
    wait_done("t5_timeout");
    // T6: async reset during the second dispense
    ack_dly = 3;
    exp_q = '{HI, HI};
    req(30);
    k = 0;
    while (!(coin_valid && coin_count == 1) && k < 100) begin @(posedge clk); #1; k++; end
    chk("t6_second_disp", 32'(coin_valid && coin_count == 1), 1);
    #2 reset = 0;
    #1;
    chk("t6_ready", 32'(ready), 1);
    chk("t6_valid", 32'(coin_valid), 0);
    chk("t6_type", 32'(coin_type), 0);
    chk("t6_rem", remaining, 0);
    chk("t6_cnt", 32'(coin_count), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_fault", 32'(fault), 0);
    @(negedge clk) reset = 1;
    ack_dly = 0;
    exp_q = '{MID};
    expect_done(1);
    req(5);
    wait_done("t6_new_timeout");
    repeat (3) @(posedge clk);
    chk("coins_left", 32'(exp_q.size()), 0);
    chk("dones_left", 32'(done_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
